// File: rtl/accel_sequencer_pkg.sv
// Shared types and constants for the accelerator job sequencer.
// State, accel-type and BRAM bank encodings are visible on the host and unit ports.
package accel_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    LOAD_WEIGHTS = 3'd1,
    LOAD_INPUT   = 3'd2,
    COMPUTE      = 3'd3,
    STORE_OUTPUT = 3'd4,
    DONE         = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ACCEL_CNN     = 2'b00,
    ACCEL_RNN     = 2'b01,
    ACCEL_MLP     = 2'b10,
    ACCEL_INVALID = 2'b11
  } accel_type_e;

  typedef enum logic [4:0] {
    BANK_INPUT_0  = 5'd0,
    BANK_INPUT_1  = 5'd1,
    BANK_OUTPUT_0 = 5'd2,
    BANK_OUTPUT_1 = 5'd3,
    BANK_WEIGHTS  = 5'd4
  } bram_bank_e;

  localparam int ERR_TIMEOUT    = 0;
  localparam int ERR_BAD_TYPE   = 1;
  localparam int ERR_ABORT      = 2;
  localparam int ERR_UNEXP_DONE = 3;
  localparam int ERR_START_BUSY = 4;

  localparam int DEFAULT_PHASE_TIMEOUT = 65535;

  function automatic logic is_busy_state(input state_e s);
    return (s == LOAD_WEIGHTS) || (s == LOAD_INPUT) ||
           (s == COMPUTE)      || (s == STORE_OUTPUT);
  endfunction

  // Successor of a busy phase once its unit reports done.
  function automatic state_e next_phase(input state_e s);
    state_e n;
    case (s)
      LOAD_WEIGHTS: n = LOAD_INPUT;
      LOAD_INPUT:   n = COMPUTE;
      COMPUTE:      n = STORE_OUTPUT;
      default:      n = DONE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/accel_phase_watchdog.sv
// Per-phase cycle counter: cleared on phase entry, counts while enabled,
// and flags expiry in the cycle the count reaches LIMIT-1.
module accel_phase_watchdog
  import accel_sequencer_pkg::*;
#(
  parameter int LIMIT = DEFAULT_PHASE_TIMEOUT
)
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LAST)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expire = i_enable && (r_count == LAST);

endmodule

// File: rtl/accel_sequencer.sv
// Job sequencer: walks IDLE -> LOAD_WEIGHTS -> LOAD_INPUT -> COMPUTE -> STORE_OUTPUT
// -> DONE, launching each unit in turn and owning the ping/pong bank choice.
module accel_sequencer
  import accel_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_PHASE_TIMEOUT
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ctrl_start,
  input  logic [1:0] ctrl_accel_type,
  input  logic       ctrl_reload_weights,
  input  logic       ctrl_abort,
  output logic       busy,
  output logic       done,
  output logic [2:0] state,
  output logic [7:0] error_flags,
  output logic       ld_w_start,
  input  logic       ld_w_done,
  output logic       ld_in_start,
  input  logic       ld_in_done,
  output logic [4:0] ld_in_bank,
  output logic       cmp_start,
  input  logic       cmp_done,
  output logic [1:0] cmp_type,
  output logic [4:0] cmp_in_bank,
  output logic [4:0] cmp_out_bank,
  output logic       st_start,
  input  logic       st_done,
  output logic [4:0] st_bank
);

  // Unit handshake: *_start is a single-cycle pulse in the first cycle of the
  // unit's phase; the unit answers with a *_done pulse in any later cycle of
  // that phase. A done in the start cycle or outside the phase is an error.

  state_e     r_state, w_state_n;
  logic [7:0] r_err, w_err_n;
  logic [1:0] r_type, w_type_n;
  logic       r_pp, w_pp_n;
  logic       r_busy, r_done;
  logic       r_ld_w_start, r_ld_in_start, r_cmp_start, r_st_start;
  logic [4:0] r_in_bank, r_out_bank;
  logic       w_own_done, w_first, w_stray, w_expire, w_wd_clear;

  always_comb begin
    w_own_done = 1'b0;
    w_first    = 1'b0;
    case (r_state)
      LOAD_WEIGHTS: begin w_own_done = ld_w_done;  w_first = r_ld_w_start;  end
      LOAD_INPUT:   begin w_own_done = ld_in_done; w_first = r_ld_in_start; end
      COMPUTE:      begin w_own_done = cmp_done;   w_first = r_cmp_start;   end
      STORE_OUTPUT: begin w_own_done = st_done;    w_first = r_st_start;    end
      default:      begin end
    endcase
    w_stray = (ld_w_done  && (r_state != LOAD_WEIGHTS)) ||
              (ld_in_done && (r_state != LOAD_INPUT))   ||
              (cmp_done   && (r_state != COMPUTE))      ||
              (st_done    && (r_state != STORE_OUTPUT)) ||
              (w_own_done && w_first);
  end

  always_comb begin
    w_state_n = r_state;
    w_err_n   = r_err;
    w_type_n  = r_type;
    w_pp_n    = r_pp;
    case (r_state)
      IDLE: begin
        if (w_stray) w_err_n[ERR_UNEXP_DONE] = 1'b1;
        if (ctrl_start) begin
          w_err_n  = '0;
          w_type_n = ctrl_accel_type;
          if (ctrl_accel_type == ACCEL_INVALID) begin
            w_err_n[ERR_BAD_TYPE] = 1'b1;
            w_state_n = DONE;
          end else begin
            w_state_n = ctrl_reload_weights ? LOAD_WEIGHTS : LOAD_INPUT;
          end
        end
      end
      DONE: begin
        w_state_n = IDLE;
        if (r_err == '0) w_pp_n = ~r_pp;
        if (w_stray)     w_err_n[ERR_UNEXP_DONE] = 1'b1;
        if (ctrl_start)  w_err_n[ERR_START_BUSY] = 1'b1;
      end
      default: begin
        if (w_stray)    w_err_n[ERR_UNEXP_DONE] = 1'b1;
        if (ctrl_start) w_err_n[ERR_START_BUSY] = 1'b1;
        // Abort beats a same-cycle done; a done beats a same-cycle expiry.
        if (ctrl_abort) begin
          w_err_n[ERR_ABORT] = 1'b1;
          w_state_n = DONE;
        end else if (w_own_done && !w_first) begin
          w_state_n = next_phase(r_state);
        end else if (w_expire) begin
          w_err_n[ERR_TIMEOUT] = 1'b1;
          w_state_n = DONE;
        end
      end
    endcase
  end

  assign w_wd_clear = (w_state_n != r_state);

  accel_phase_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_wd_clear),
    .i_enable (r_busy),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_err         <= '0;
      r_type        <= '0;
      r_pp          <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_ld_w_start  <= 1'b0;
      r_ld_in_start <= 1'b0;
      r_cmp_start   <= 1'b0;
      r_st_start    <= 1'b0;
      r_in_bank     <= 5'(BANK_INPUT_0);
      r_out_bank    <= 5'(BANK_OUTPUT_0);
    end else begin
      r_state       <= w_state_n;
      r_err         <= w_err_n;
      r_type        <= w_type_n;
      r_pp          <= w_pp_n;
      r_busy        <= is_busy_state(w_state_n);
      r_done        <= (w_state_n == DONE);
      r_ld_w_start  <= (w_state_n == LOAD_WEIGHTS) && (r_state != LOAD_WEIGHTS);
      r_ld_in_start <= (w_state_n == LOAD_INPUT)   && (r_state != LOAD_INPUT);
      r_cmp_start   <= (w_state_n == COMPUTE)      && (r_state != COMPUTE);
      r_st_start    <= (w_state_n == STORE_OUTPUT) && (r_state != STORE_OUTPUT);
      r_in_bank     <= 5'(BANK_INPUT_0)  + {4'd0, w_pp_n};
      r_out_bank    <= 5'(BANK_OUTPUT_0) + {4'd0, w_pp_n};
    end
  end

  assign state        = r_state;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error_flags  = r_err;
  assign ld_w_start   = r_ld_w_start;
  assign ld_in_start  = r_ld_in_start;
  assign cmp_start    = r_cmp_start;
  assign st_start     = r_st_start;
  assign cmp_type     = r_type;
  assign ld_in_bank   = r_in_bank;
  assign cmp_in_bank  = r_in_bank;
  assign cmp_out_bank = r_out_bank;
  assign st_bank      = r_out_bank;

endmodule

// File: doc/accel_sequencer.md
# accel_sequencer

Top-level job sequencer for the accelerator framework. Accepts one job request at a time and walks the unified state flow: IDLE, LOAD_WEIGHTS, LOAD_INPUT, COMPUTE, STORE_OUTPUT, DONE. It launches the weight loader, input loader, compute core and output store units in turn, and assigns ping/pong input and output BRAM banks. It also reports job status and error flags back to the host control interface.

## Interface
Parameters:
- TIMEOUT_CYCLES, 65535: per-phase watchdog limit, in cycles.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- ctrl_start  in  1  job request; sampled only in IDLE
- ctrl_accel_type  in  2  accel_type_e; captured when a start is accepted
- ctrl_reload_weights  in  1  captured with start; 0 skips LOAD_WEIGHTS
- ctrl_abort  in  1  abort the current job
- busy  out  1  high in LOAD_WEIGHTS, LOAD_INPUT, COMPUTE and STORE_OUTPUT
- done  out  1  one-cycle pulse; equals state==DONE
- state  out  3  state_e encoding of the current state
- error_flags  out  8  sticky error bits
- ld_w_start / ld_w_done  out / in  1  weight loader handshake
- ld_in_start / ld_in_done  out / in  1  input loader handshake
- ld_in_bank  out  5  BANK_INPUT_0 or BANK_INPUT_1
- cmp_start / cmp_done  out / in  1  compute core handshake
- cmp_type  out  2  captured accel type
- cmp_in_bank, cmp_out_bank  out  5  current input bank and current output bank
- st_start / st_done  out / in  1  output store handshake
- st_bank  out  5  BANK_OUTPUT_0 or BANK_OUTPUT_1

## Operation
- Ping/pong bit pp, reset value 0. Bank assignments:
  - ld_in_bank = cmp_in_bank = BANK_INPUT_0 + pp.
  - cmp_out_bank = st_bank = BANK_OUTPUT_0 + pp.
  - pp toggles on DONE exit only when error_flags == 0.
- Start accepted in IDLE when ctrl_start = 1:
  - Clears error_flags.
  - Captures type and reload.
  - Next state is LOAD_WEIGHTS if reload = 1, else LOAD_INPUT.
  - Type 2'b11 is invalid: next state is DONE, bit1 is set, no units are started.
- Phase advance: LOAD_WEIGHTS → LOAD_INPUT → COMPUTE → STORE_OUTPUT → DONE → IDLE. A phase advances when its *_done is seen.
- Each *_start is a one-cycle pulse in the first cycle of its phase.
- *_done handling:
  - A *_done in the start-pulse cycle is ignored and sets bit3.
  - Any *_done from a unit not in its phase sets bit3 and has no other effect.
- Abort in a busy state: next state is DONE and bit2 is set. Abort has priority over a *_done in the same cycle. Abort is ignored in IDLE and DONE.
- Watchdog:
  - The counter clears on every phase entry.
  - If the count reaches TIMEOUT_CYCLES-1 with no done, set bit0 and next state is DONE.
  - A done arriving in that same cycle wins: normal advance, no flag.
- ctrl_start while busy or in DONE is ignored and sets bit4.
- error_flags: bit0 timeout, bit1 invalid type, bit2 abort, bit3 unexpected done, bit4 start-while-busy, bits7:5 = 0.

## Timing
- Reset values: state IDLE, busy 0, done 0, error_flags 0, all *_start 0, pp 0, cmp_type 0, ld_in_bank/cmp_in_bank = 0, cmp_out_bank/st_bank = 2.
- All outputs are registered.
- Start latency: start seen at cycle t gives state LOAD_x at t+1, with the matching *_start high at t+1.
- Phase latency: *_done at cycle c gives the next state at c+1, with the next *_start at c+1.
- Minimum job with reload = 0 and every done returned one cycle after its start: start at 0, done pulse at 7, IDLE at 8.
- Bank outputs and cmp_type are stable from start acceptance through DONE. They change only on pp toggle or on a new start.
- Reset mid-job: within one cycle all outputs return to reset values and pp returns to 0; no done pulse.

## Structure
- Add to the shared package:
  - error bit index localparams (ERR_TIMEOUT=0, ERR_BAD_TYPE=1, ERR_ABORT=2, ERR_UNEXP_DONE=3, ERR_START_BUSY=4);
  - the DEFAULT_PHASE_TIMEOUT constant.
- Reuse the package's state_e, accel_type_e and bram_bank_e.
- One sub-module: accel_phase_watchdog. It is a counter with clear and enable inputs and emits a one-cycle expire pulse.

## Test plan
- Full job: reload=1, type=ACCEL_CNN, each done returned 3 cycles after its start → states 1,2,3,4,5,0; ld_in_bank=0, st_bank=2; error_flags=0. A second job uses banks 1 and 3.
- Invalid type: start with type=2'b11 → DONE on the next cycle, error_flags=8'h02, no *_start pulses, pp unchanged; next job uses bank 0.
- Abort: assert in COMPUTE together with cmp_done → DONE, error_flags=8'h04, pp not toggled.
- Timeout: TIMEOUT_CYCLES=16, ld_in_done never returned → DONE 16 cycles after LOAD_INPUT entry, error_flags=8'h01.
- Stray handshake: st_done during LOAD_INPUT, plus ctrl_start while busy → error_flags=8'h18 at DONE; the job otherwise completes normally.
- Reset: rst_n=0 for 1 cycle in STORE_OUTPUT → all outputs at reset values next cycle, no done pulse.
